case9_resp_misr: RTL and testbench



---
 rtl/case9_resp_misr.sv | 123 ++++++++++++
 tb/tb_case9_resp_misr.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/case9_resp_misr.sv
// case9_resp_misr: folds case9 outputs y1..y5 into a 16-bit MISR over NVEC vectors and checks against golden.
// Optional feature macro CASE9_MISR_ONECNT_EN adds the ones_cnt activity counter output.
module case9_resp_misr #(
  parameter int unsigned NVEC = 16,
  parameter logic [15:0] POLY = 16'h1021,
  parameter logic [15:0] SEED = 16'hFFFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] golden,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        y1,
  input  logic        y2,
  input  logic        y3,
  input  logic        y4,
  input  logic        y5,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] signature,
  output logic [15:0] vec_cnt
`ifdef CASE9_MISR_ONECNT_EN
  ,
  output logic [19:0] ones_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    CMP  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [15:0] LAST_CNT = 16'(NVEC - 32'd1);

  // One GF(2) MISR step: shift, conditional polynomial feedback, inject the zero-extended vector.
  function automatic logic [15:0] misr_step(input logic [15:0] sig, input logic [4:0] v);
    misr_step = {sig[14:0], 1'b0} ^ (sig[15] ? POLY : 16'h0000) ^ {11'b000_0000_0000, v};
  endfunction

`ifdef CASE9_MISR_ONECNT_EN
  function automatic logic [2:0] popcount5(input logic [4:0] v);
    popcount5 = {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]} + {2'b00, v[4]};
  endfunction
`endif

  state_t     state_r;
  logic [4:0] vec_s;
  logic       accept_s;

  assign vec_s    = {y5, y4, y3, y2, y1};
  // in_ready is a flop, so accept never depends combinationally on in_valid through the FSM.
  assign accept_s = in_valid & in_ready;

  // Control FSM with registered handshake/status outputs and the MISR datapath.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      in_ready  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      signature <= SEED;
      vec_cnt   <= 16'd0;
`ifdef CASE9_MISR_ONECNT_EN
      ones_cnt  <= 20'd0;
`endif
    end else begin
      case (state_r)
        IDLE, DONE: begin
          if (start) begin
            state_r   <= RUN;
            in_ready  <= 1'b1;
            busy      <= 1'b1;
            done      <= 1'b0;
            pass      <= 1'b0;
            signature <= SEED;
            vec_cnt   <= 16'd0;
`ifdef CASE9_MISR_ONECNT_EN
            ones_cnt  <= 20'd0;
`endif
          end else begin
            state_r <= state_r;
          end
        end
        RUN: begin
          if (accept_s) begin
            signature <= misr_step(signature, vec_s);
            vec_cnt   <= vec_cnt + 16'd1;
`ifdef CASE9_MISR_ONECNT_EN
            ones_cnt  <= ones_cnt + {17'd0, popcount5(vec_s)};
`endif
            if (vec_cnt == LAST_CNT) begin
              state_r  <= CMP;
              in_ready <= 1'b0;
            end else begin
              state_r <= RUN;
            end
          end else begin
            state_r <= RUN;
          end
        end
        CMP: begin
          pass    <= (signature == golden);
          state_r <= DONE;
          busy    <= 1'b0;
          done    <= 1'b1;
        end
        default: begin
          state_r  <= IDLE;
          in_ready <= 1'b0;
          busy     <= 1'b0;
          done     <= 1'b0;
          pass     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_case9_resp_misr.sv
// Self-checking bench for case9_resp_misr: vector table on an NVEC=1 instance, randomized runs on NVEC=16.
module tb_case9_resp_misr;

  logic        clk = 1'b0;
  logic        rst_n, start1, start16, in_valid;
  logic [4:0]  v;
  logic [15:0] golden;

  logic        rdy1, busy1, done1, pass1;
  logic [15:0] sig1, cnt1;
  logic        rdy16, busy16, done16, pass16;
  logic [15:0] sig16, cnt16;
`ifdef CASE9_MISR_ONECNT_EN
  logic        start4, rdy4, busy4, done4, pass4;
  logic [15:0] sig4, cnt4;
  logic [19:0] oc1, oc16, oc4;
`endif

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  case9_resp_misr #(.NVEC(1)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .golden(golden), .in_valid(in_valid),
    .in_ready(rdy1), .y1(v[0]), .y2(v[1]), .y3(v[2]), .y4(v[3]), .y5(v[4]),
    .busy(busy1), .done(done1), .pass(pass1), .signature(sig1), .vec_cnt(cnt1)
`ifdef CASE9_MISR_ONECNT_EN
    , .ones_cnt(oc1)
`endif
  );

  case9_resp_misr #(.NVEC(16)) u16 (
    .clk(clk), .rst_n(rst_n), .start(start16), .golden(golden), .in_valid(in_valid),
    .in_ready(rdy16), .y1(v[0]), .y2(v[1]), .y3(v[2]), .y4(v[3]), .y5(v[4]),
    .busy(busy16), .done(done16), .pass(pass16), .signature(sig16), .vec_cnt(cnt16)
`ifdef CASE9_MISR_ONECNT_EN
    , .ones_cnt(oc16)
`endif
  );

`ifdef CASE9_MISR_ONECNT_EN
  case9_resp_misr #(.NVEC(4)) u4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .golden(golden), .in_valid(in_valid),
    .in_ready(rdy4), .y1(v[0]), .y2(v[1]), .y3(v[2]), .y4(v[3]), .y5(v[4]),
    .busy(busy4), .done(done4), .pass(pass4), .signature(sig4), .vec_cnt(cnt4),
    .ones_cnt(oc4)
  );
`endif

  typedef struct {
    logic [4:0]  v;
    logic [15:0] golden;
    logic [15:0] exp_sig;
    logic        exp_pass;
  } vec1_t;

  vec1_t tbl[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Signature polynomial arithmetic over integers: multiply by x mod (x^16+x^12+x^5+1), add v.
  function automatic int model_step(input int s, input int vin);
    int t;
    t = (s * 2) % 65536;
    if (s >= 32768) t = t ^ 'h1021;
    return t ^ vin;
  endfunction

  initial begin
    int s, n, cyc;
    bit exp_acc;

    tbl[0] = '{5'h00, 16'hEFDF, 16'hEFDF, 1'b1};
    tbl[1] = '{5'h1F, 16'hEFDF, 16'hEFC0, 1'b0};
    tbl[2] = '{5'h01, 16'hEFDE, 16'hEFDE, 1'b1};
    tbl[3] = '{5'h0A, 16'h0000, 16'hEFD5, 1'b0};

    rst_n = 1'b0; start1 = 1'b0; start16 = 1'b0; in_valid = 1'b0; v = 5'd0; golden = 16'd0;
`ifdef CASE9_MISR_ONECNT_EN
    start4 = 1'b0;
`endif
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    check("reset_sig", sig1, 16'hFFFF);
    check("reset_ready", rdy1, 0);
    check("reset_done", done1, 0);
    check("reset_pass", pass1, 0);
    check("reset_busy", busy1, 0);
    check("reset_cnt", cnt16, 0);

    // NVEC=1 table: start issued with in_valid high must not accept that cycle.
    for (int i = 0; i < 4; i++) begin
      start1 = 1'b1; in_valid = 1'b1; v = tbl[i].v; golden = tbl[i].golden;
      tick();
      start1 = 1'b0;
      check("t_start_ready", rdy1, 1);
      check("t_start_cnt", cnt1, 0);
      check("t_start_sig", sig1, 16'hFFFF);
      check("t_start_busy", busy1, 1);
      check("t_start_done", done1, 0);
      tick();
      in_valid = 1'b0;
      check("t_acc_sig", sig1, tbl[i].exp_sig);
      check("t_acc_cnt", cnt1, 1);
      check("t_acc_ready", rdy1, 0);
      check("t_cmp_done", done1, 0);
      tick();
      check("t_done", done1, 1);
      check("t_pass", pass1, tbl[i].exp_pass);
      check("t_done_busy", busy1, 0);
      tick();
      check("t_hold_done", done1, 1);
      check("t_hold_sig", sig1, tbl[i].exp_sig);
    end

    // NVEC=16, in_valid alternating, stray start during RUN.
    s = 'hFFFF; n = 0;
    start16 = 1'b1; in_valid = 1'b0;
    tick();
    start16 = 1'b0;
    for (int i = 0; i < 32; i++) begin
      in_valid = (i % 2 == 0);
      v = 5'($urandom);
      start16 = (i == 10);
      exp_acc = in_valid && (n < 16);
      tick();
      if (exp_acc) begin
        s = model_step(s, int'(v));
        n++;
      end
      golden = 16'(s);
      check("tog_cnt", cnt16, n);
      check("tog_ready", rdy16, (n < 16) ? 1 : 0);
    end
    start16 = 1'b0; in_valid = 1'b0;
    check("tog_sig", sig16, s);
    check("tog_done", done16, 1);
    check("tog_pass", pass16, 1);

    // Randomized valid patterns, one run with a wrong golden.
    for (int r = 0; r < 3; r++) begin
      s = 'hFFFF; n = 0; cyc = 0;
      start16 = 1'b1; in_valid = 1'b0;
      tick();
      start16 = 1'b0;
      while (n < 16 && cyc < 200) begin
        in_valid = 1'($urandom);
        v = 5'($urandom);
        tick();
        cyc++;
        if (in_valid) begin
          s = model_step(s, int'(v));
          n++;
        end
      end
      golden = (r == 1) ? 16'(s ^ 1) : 16'(s);
      in_valid = 1'($urandom);
      check("rnd_timeout", (cyc < 200) ? 1 : 0, 1);
      check("rnd_sig", sig16, s);
      check("rnd_cnt", cnt16, 16);
      check("rnd_cmp_done", done16, 0);
      tick();
      in_valid = 1'b0;
      check("rnd_done", done16, 1);
      check("rnd_pass", pass16, (r == 1) ? 0 : 1);
      check("rnd_hold_cnt", cnt16, 16);
    end

    // Reset after 5 accepts, then a clean run must match the model.
    start16 = 1'b1;
    tick();
    start16 = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      v = 5'(i * 7 + 3);
      tick();
    end
    in_valid = 1'b0;
    check("mid_cnt_before", cnt16, 5);
    rst_n = 1'b0;
    #1;
    check("mid_rst_sig", sig16, 16'hFFFF);
    check("mid_rst_cnt", cnt16, 0);
    check("mid_rst_ready", rdy16, 0);
    check("mid_rst_busy", busy16, 0);
    check("mid_rst_done", done16, 0);
    check("mid_rst_pass", pass16, 0);
    #1;
    rst_n = 1'b1;
    tick();
    s = 'hFFFF;
    start16 = 1'b1;
    tick();
    start16 = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      v = 5'(i * 7 + 3);
      s = model_step(s, int'(v));
      tick();
    end
    in_valid = 1'b0;
    golden = 16'(s);
    check("clean_sig", sig16, s);
    tick();
    check("clean_done", done16, 1);
    check("clean_pass", pass16, 1);

`ifdef CASE9_MISR_ONECNT_EN
    start4 = 1'b1;
    tick();
    start4 = 1'b0;
    check("ones_clear", oc4, 0);
    in_valid = 1'b1;
    v = 5'h1F; tick();
    v = 5'h00; tick();
    v = 5'h03; tick();
    v = 5'h10; tick();
    in_valid = 1'b0;
    tick();
    check("ones_done", done4, 1);
    check("ones_cnt", oc4, 8);
    tick();
    check("ones_hold", oc4, 8);
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
